sort_network: RTL and testbench
===============================

Name: sort_network

Overview:
- Parametrised, fully pipelined odd-even transposition sorting network; successor to the 2-input compare/exchange cell.
- Sorts N_ELEMENTS packed elements per beat by their DATA field. USER and DEST fields travel with their element.
- Valid/ready streaming handshake with full backpressure. Ascending or descending order selected per beat.
- Sits between a sample-gathering stage and downstream selection/min-max logic in the system block.

Parameters:
DATA_WIDTH, 32, width of the sort key (element bits [DATA_WIDTH-1:0])
USER_WIDTH, 32, width of user sideband (next bits above DATA)
DEST_WIDTH, 32, width of dest sideband (top bits)
N_ELEMENTS, 4, elements per beat; legal range 2..64

Ports:
clock  in  1  system clock; all logic on rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat
in_descending  in  1  order for this beat: 0 ascending, 1 descending
data_in  in  [EL_W-1:0] x N_ELEMENTS (unpacked)  elements; EL_W = DATA_WIDTH+USER_WIDTH+DEST_WIDTH
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts beat
data_out  out  [EL_W-1:0] x N_ELEMENTS  sorted elements
busy  out  1  any pipeline stage holds a valid beat

Behaviour:
- Pipeline stages:
  - N_ELEMENTS register stages S0..S(N-1).
  - Each stage holds: valid bit, descending bit, N elements.
  - Stage k compare/exchanges adjacent pairs (i,i+1) with i even when k is even, i odd when k is odd, i+1 < N. Unpaired elements pass straight through.
- Compare rule:
  - Compare unsigned on bits [DATA_WIDTH-1:0] only.
  - Ascending: swap iff key[i] > key[i+1] (strict).
  - Descending: swap iff key[i] < key[i+1] (strict).
  - Equal keys are never swapped, so the sort is stable and USER/DEST order of equal keys is preserved.
  - A swap moves the whole EL_W element.
- Handshake:
  - stage_ready[k] = !valid[k] || stage_ready[k+1]; the last stage uses out_ready.
  - in_ready = stage_ready[0]. This is a combinational chain; no skid buffer.
  - Stage k loads from stage k-1 (S0 loads from the inputs) when stage_ready[k].
  - valid[k] <= valid[k-1]; S0 loads in_valid && in_ready.
  - Transfer occurs only when valid && ready are both high in the same cycle.
- Outputs:
  - out_valid = valid[N-1]; data_out = S(N-1) elements.
  - Output holds stable while out_valid && !out_ready.
  - busy = OR of all stage valid bits.
- Latency and throughput:
  - Exactly N_ELEMENTS cycles from input acceptance to out_valid, with no backpressure.
  - Throughput 1 beat/cycle.
  - With out_ready held low the pipeline fills, holding up to N_ELEMENTS beats, then in_ready drops in the same cycle the last stage stalls.
- Bubbles:
  - Invalid stages collapse when downstream stalls; a bubble never blocks a valid beat.
- Mode:
  - in_descending is captured with the beat and carried through the stages.
  - Mixed-mode beats in flight each sort in their own order.
- Reset (asserted low, any time including mid-stream):
  - All stage valid bits, descending bits and element registers clear to 0 immediately.
  - out_valid=0, busy=0, data_out all zero, in_ready=1.
  - In-flight beats are discarded; no partial beat is ever emitted after release.
- Simultaneous events: accept at S0 and emit at the last stage in the same cycle is legal and required for full throughput.

Optional Feature:
- Macro SORT_NETWORK_SIGNED_EN.
- Defined: the key compare treats bits [DATA_WIDTH-1:0] as two's-complement signed. Swap rules are otherwise unchanged.
- Undefined: unsigned compare as above.
- Ports, latency and handshake are identical in both builds.

Test Plan:
- N=4, ascending, keys [7,3,9,1], out_ready=1 -> exactly 4 cycles later out_valid=1, keys [1,3,7,9], USER fields follow their keys.
- Same keys with in_descending=1 -> [9,7,3,1]. Next beat ascending [2,2,0,5] issued back-to-back -> [0,2,2,5]; the two key-2 elements keep their input USER order (tags 0xA then 0xB).
- Stream 6 ascending beats with out_ready=0 -> in_ready falls after 4 accepted beats, busy=1, data_out stable. Raise out_ready -> all 6 beats emitted in order, each correctly sorted, none lost or duplicated.
- Assert reset for 1 cycle while 3 beats are in flight -> out_valid=0, busy=0, data_out=0, in_ready=1 immediately. No stale beat appears after release.
- N=2 with keys [5,5] and keys [8,1] -> outputs [5,5] (no swap) and [1,8], latency 2 cycles.
- SORT_NETWORK_SIGNED_EN defined, DATA_WIDTH=8, keys [0x01,0xFF,0x80,0x7F] ascending -> [0x80,0xFF,0x01,0x7F]. Undefined build -> [0x01,0x7F,0x80,0xFF].

Source files
------------

// File: rtl/sort_network.sv
// Fully pipelined odd-even transposition sorter: N_ELEMENTS stages, stable, per-beat order.
// Optional build macro SORT_NETWORK_SIGNED_EN selects a two's-complement key compare.
module sort_network #(
    parameter int DATA_WIDTH = 32,
    parameter int USER_WIDTH = 32,
    parameter int DEST_WIDTH = 32,
    parameter int N_ELEMENTS = 4,
    localparam int EL_W = DATA_WIDTH + USER_WIDTH + DEST_WIDTH
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_descending,
    input  logic [EL_W-1:0] data_in [N_ELEMENTS],
    output logic            out_valid,
    input  logic            out_ready,
    output logic [EL_W-1:0] data_out [N_ELEMENTS],
    output logic            busy
);

    logic [N_ELEMENTS-1:0] stage_valid;
    logic [N_ELEMENTS-1:0] stage_desc;
    logic [N_ELEMENTS-1:0] stage_ready;
    logic [EL_W-1:0]       stage_q [N_ELEMENTS][N_ELEMENTS];

    logic [N_ELEMENTS-1:0] src_valid;
    logic [N_ELEMENTS-1:0] src_desc;
    logic [EL_W-1:0]       src [N_ELEMENTS+1][N_ELEMENTS];
    logic [EL_W-1:0]       nxt [N_ELEMENTS][N_ELEMENTS];
    logic                  chain;

    function automatic logic need_swap(input logic [EL_W-1:0] a,
                                       input logic [EL_W-1:0] b,
                                       input logic            desc);
`ifdef SORT_NETWORK_SIGNED_EN
        logic signed [DATA_WIDTH-1:0] ka;
        logic signed [DATA_WIDTH-1:0] kb;
`else
        logic [DATA_WIDTH-1:0] ka;
        logic [DATA_WIDTH-1:0] kb;
`endif
        ka = a[DATA_WIDTH-1:0];
        kb = b[DATA_WIDTH-1:0];
        // Strict compares keep equal keys in place, which makes the sort stable.
        return desc ? (ka < kb) : (ka > kb);
    endfunction

    // Handshake: a beat moves into stage k on a rising edge when the upstream
    // side is valid and stage_ready[k] is high; stage k is ready when it is
    // empty or its own beat moves on in the same cycle (last stage: out_ready).
    always_comb begin
        chain       = out_ready;
        stage_ready = '0;
        for (int k = N_ELEMENTS - 1; k >= 0; k--) begin
            chain          = !stage_valid[k] || chain;
            stage_ready[k] = chain;
        end
    end

    assign src_valid = {stage_valid[N_ELEMENTS-2:0], in_valid};
    assign src_desc  = {stage_desc[N_ELEMENTS-2:0], in_descending};

    always_comb begin
        src[0] = data_in;
        for (int k = 0; k < N_ELEMENTS; k++) begin
            src[k+1] = stage_q[k];
        end
    end

    // Even stages pair (0,1),(2,3)...; odd stages pair (1,2),(3,4)...
    always_comb begin
        for (int k = 0; k < N_ELEMENTS; k++) begin
            for (int i = 0; i < N_ELEMENTS; i++) begin
                nxt[k][i] = src[k][i];
            end
            for (int i = k % 2; i + 1 < N_ELEMENTS; i += 2) begin
                if (need_swap(src[k][i], src[k][i+1], src_desc[k])) begin
                    nxt[k][i]   = src[k][i+1];
                    nxt[k][i+1] = src[k][i];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stage_valid <= '0;
            stage_desc  <= '0;
            for (int k = 0; k < N_ELEMENTS; k++) begin
                for (int i = 0; i < N_ELEMENTS; i++) begin
                    stage_q[k][i] <= '0;
                end
            end
        end else begin
            for (int k = 0; k < N_ELEMENTS; k++) begin
                if (stage_ready[k]) begin
                    stage_valid[k] <= src_valid[k];
                    stage_desc[k]  <= src_desc[k];
                    stage_q[k]     <= nxt[k];
                end
            end
        end
    end

    assign in_ready  = stage_ready[0];
    assign out_valid = stage_valid[N_ELEMENTS-1];
    assign data_out  = stage_q[N_ELEMENTS-1];
    assign busy      = |stage_valid;

endmodule

// File: tb/tb_sort_network.sv
// Bench for sort_network: directed plan steps plus a randomized backpressured stream,
// checked against a stable insertion-sort reference model.
module tb_sort_network;

    localparam int DW   = 8;
    localparam int EL_W = 3 * DW;
    localparam int BW   = 4 * EL_W;
    localparam int N_RAND = 24;

    logic            clock;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic            in_descending;
    logic [EL_W-1:0] data_in [4];
    logic            out_valid;
    logic            out_ready;
    logic [EL_W-1:0] data_out [4];
    logic            busy;

    logic            in2_valid;
    logic            in2_ready;
    logic            in2_desc;
    logic [EL_W-1:0] d2_in [2];
    logic            out2_valid;
    logic            out2_ready;
    logic [EL_W-1:0] d2_out [2];
    logic            busy2;

    logic [BW-1:0] exp_q [$];
    int n_checks = 0;
    int n_pass   = 0;
    int n_out    = 0;

    sort_network #(.DATA_WIDTH(DW), .USER_WIDTH(DW), .DEST_WIDTH(DW), .N_ELEMENTS(4)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_descending(in_descending),
        .data_in(data_in),
        .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
        .busy(busy)
    );

    sort_network #(.DATA_WIDTH(DW), .USER_WIDTH(DW), .DEST_WIDTH(DW), .N_ELEMENTS(2)) dut2 (
        .clock(clock), .reset(reset),
        .in_valid(in2_valid), .in_ready(in2_ready), .in_descending(in2_desc),
        .data_in(d2_in),
        .out_valid(out2_valid), .out_ready(out2_ready), .data_out(d2_out),
        .busy(busy2)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // reference model
    function automatic longint key(input logic [EL_W-1:0] x);
`ifdef SORT_NETWORK_SIGNED_EN
        return longint'($signed(x[DW-1:0]));
`else
        return longint'(x[DW-1:0]);
`endif
    endfunction

    function automatic logic [BW-1:0] ref_sort(input logic [BW-1:0] b, input logic desc);
        logic [EL_W-1:0] lst [$];
        logic [EL_W-1:0] x;
        logic [BW-1:0]   r;
        int p;
        for (int i = 0; i < 4; i++) begin
            x = b[i*EL_W +: EL_W];
            p = 0;
            while (p < lst.size() &&
                   !(desc ? (key(x) > key(lst[p])) : (key(x) < key(lst[p]))))
                p++;
            lst.insert(p, x);
        end
        r = '0;
        for (int i = 0; i < 4; i++) r[i*EL_W +: EL_W] = lst[i];
        return r;
    endfunction

    function automatic logic [EL_W-1:0] el(input int k, input int u, input int d);
        return {d[DW-1:0], u[DW-1:0], k[DW-1:0]};
    endfunction

    function automatic logic [BW-1:0] beat4(input logic [EL_W-1:0] e0, input logic [EL_W-1:0] e1,
                                            input logic [EL_W-1:0] e2, input logic [EL_W-1:0] e3);
        return {e3, e2, e1, e0};
    endfunction

    function automatic logic [BW-1:0] rand_beat();
        logic [BW-1:0] r;
        for (int i = 0; i < 4; i++)
            r[i*EL_W +: EL_W] = el(($urandom_range(0, 1) != 0) ? $urandom_range(0, 3) : $urandom_range(0, 255),
                                   $urandom_range(0, 255), $urandom_range(0, 255));
        return r;
    endfunction

    function automatic logic [BW-1:0] cur_in();
        logic [BW-1:0] r;
        for (int i = 0; i < 4; i++) r[i*EL_W +: EL_W] = data_in[i];
        return r;
    endfunction

    function automatic logic [BW-1:0] cur_out();
        logic [BW-1:0] r;
        for (int i = 0; i < 4; i++) r[i*EL_W +: EL_W] = data_out[i];
        return r;
    endfunction

    function automatic logic [BW-1:0] cur_out2();
        logic [BW-1:0] r;
        r = '0;
        r[2*EL_W-1:0] = {d2_out[1], d2_out[0]};
        return r;
    endfunction

    // driver tasks (called at posedge + 1)
    task automatic set_in(input logic [BW-1:0] b, input logic desc);
        for (int i = 0; i < 4; i++) data_in[i] = b[i*EL_W +: EL_W];
        in_descending = desc;
    endtask

    task automatic wait_accept(input string tag);
        int n = 0;
        @(negedge clock);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clock);
        end
        check(tag, BW'(in_ready), BW'(1));
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [BW-1:0] b, input logic desc);
        set_in(b, desc);
        in_valid = 1'b1;
        wait_accept("accept");
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < 200) begin
            n++;
            @(negedge clock);
        end
        check("drain_queue_empty", BW'(exp_q.size()), BW'(0));
        check("drain_busy", BW'(busy), BW'(0));
        @(posedge clock);
        #1;
    endtask

    // scoreboard: observes handshakes at negedge, inputs only change at posedge + 1
    always @(negedge clock) begin
        if (!reset) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                check("pop_expected", BW'(exp_q.size() != 0), BW'(1));
                if (exp_q.size() != 0) begin
                    check("beat_data", cur_out(), exp_q[0]);
                    void'(exp_q.pop_front());
                    n_out++;
                end
            end
            if (in_valid && in_ready) exp_q.push_back(ref_sort(cur_in(), in_descending));
        end
    end

    initial begin
        int lat;
        int base;
        int sent;
        int cyc;
        int seen;
        logic took;
        logic [BW-1:0] b;
        logic [BW-1:0] exp_signed;

        reset = 1'b0;
        in_valid = 1'b0;
        in_descending = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) data_in[i] = '0;
        in2_valid = 1'b0;
        in2_desc = 1'b0;
        out2_ready = 1'b1;
        d2_in[0] = '0;
        d2_in[1] = '0;
        #3;
        check("rst_out_valid", BW'(out_valid), BW'(0));
        check("rst_busy", BW'(busy), BW'(0));
        check("rst_in_ready", BW'(in_ready), BW'(1));
        check("rst_data_out", cur_out(), BW'(0));
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;

        // ascending [7,3,9,1], latency
        send(beat4(el(7, 'hA0, 'hD0), el(3, 'hA1, 'hD1), el(9, 'hA2, 'hD2), el(1, 'hA3, 'hD3)), 1'b0);
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
        end while (!out_valid && lat < 20);
        check("latency_n4", BW'(lat), BW'(4));
        check("asc_7391", cur_out(),
              beat4(el(1, 'hA3, 'hD3), el(3, 'hA1, 'hD1), el(7, 'hA0, 'hD0), el(9, 'hA2, 'hD2)));
        @(posedge clock);
        #1;

        // descending then ascending back-to-back, stability of equal keys
        send(beat4(el(7, 1, 0), el(3, 2, 0), el(9, 3, 0), el(1, 4, 0)), 1'b1);
        send(beat4(el(2, 'hA, 0), el(2, 'hB, 0), el(0, 'hC, 0), el(5, 'hD, 0)), 1'b0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        check("desc_9731", cur_out(), beat4(el(9, 3, 0), el(7, 1, 0), el(3, 2, 0), el(1, 4, 0)));
        @(negedge clock);
        check("b2b_valid", BW'(out_valid), BW'(1));
        check("stable_2205", cur_out(), beat4(el(0, 'hC, 0), el(2, 'hA, 0), el(2, 'hB, 0), el(5, 'hD, 0)));
        @(posedge clock);
        #1;
        wait_idle();

        // fill under backpressure
        base = n_out;
        out_ready = 1'b0;
        for (int j = 0; j < 4; j++) send(rand_beat(), 1'b0);
        set_in(rand_beat(), 1'b0);
        in_valid = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clock);
            check("full_in_ready", BW'(in_ready), BW'(0));
            check("full_busy", BW'(busy), BW'(1));
            check("full_out_valid", BW'(out_valid), BW'(1));
            check("full_hold_data", cur_out(), exp_q[0]);
        end
        @(posedge clock);
        #1;
        out_ready = 1'b1;
        wait_accept("accept_after_stall");
        send(rand_beat(), 1'b0);
        wait_idle();
        check("stall_beats_out", BW'(n_out - base), BW'(6));

        // reset with three beats in flight
        for (int j = 0; j < 3; j++) send(rand_beat(), j[0]);
        reset = 1'b0;
        #1;
        check("midrst_out_valid", BW'(out_valid), BW'(0));
        check("midrst_busy", BW'(busy), BW'(0));
        check("midrst_data_out", cur_out(), BW'(0));
        check("midrst_in_ready", BW'(in_ready), BW'(1));
        @(posedge clock);
        #1;
        reset = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clock);
            if (out_valid) seen++;
        end
        check("no_stale_beat", BW'(seen), BW'(0));
        @(posedge clock);
        #1;

        // key interpretation
        b = beat4(el('h01, 0, 0), el('hFF, 1, 0), el('h80, 2, 0), el('h7F, 3, 0));
`ifdef SORT_NETWORK_SIGNED_EN
        exp_signed = beat4(el('h80, 2, 0), el('hFF, 1, 0), el('h01, 0, 0), el('h7F, 3, 0));
`else
        exp_signed = beat4(el('h01, 0, 0), el('h7F, 3, 0), el('h80, 2, 0), el('hFF, 1, 0));
`endif
        send(b, 1'b0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        check("key_sign_mode", cur_out(), exp_signed);
        @(posedge clock);
        #1;
        wait_idle();

        // randomized stream, random order and backpressure
        base = n_out;
        sent = 0;
        cyc = 0;
        took = 1'b0;
        while (sent < N_RAND && cyc < 2000) begin
            @(posedge clock);
            #1;
            cyc++;
            if (took) in_valid = 1'b0;
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid && $urandom_range(0, 3) != 0) begin
                set_in(rand_beat(), 1'($urandom_range(0, 1)));
                in_valid = 1'b1;
            end
            @(negedge clock);
            took = in_valid && in_ready;
            if (took) sent++;
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("rand_all_sent", BW'(sent), BW'(N_RAND));
        wait_idle();
        check("rand_beats_out", BW'(n_out - base), BW'(N_RAND));

        // two-element instance: equal keys and a swap, latency 2
        check("n2_in_ready", BW'(in2_ready), BW'(1));
        d2_in[0] = el(5, 1, 0);
        d2_in[1] = el(5, 2, 0);
        in2_valid = 1'b1;
        @(posedge clock);
        #1;
        d2_in[0] = el(8, 3, 0);
        d2_in[1] = el(1, 4, 0);
        @(negedge clock);
        check("n2_not_early", BW'(out2_valid), BW'(0));
        @(posedge clock);
        #1;
        in2_valid = 1'b0;
        @(negedge clock);
        check("n2_latency_valid", BW'(out2_valid), BW'(1));
        check("n2_equal_keys", cur_out2(), BW'({el(5, 2, 0), el(5, 1, 0)}));
        @(negedge clock);
        check("n2_second_valid", BW'(out2_valid), BW'(1));
        check("n2_swap", cur_out2(), BW'({el(8, 3, 0), el(1, 4, 0)}));
        @(negedge clock);
        check("n2_drained", BW'(busy2), BW'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
